// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory, redirect and decoder-side signals.
// master: the fetch unit; slave: memory, execute and decoder side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generator, single outstanding request, 2-entry output FIFO.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirects enter a fault state instead of being rounded.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic [31:0] pc_q, pc_d;
    entry_t      fifo_q [2];
    entry_t      fifo_d [2];
    logic [1:0]  count_q, count_d;
    logic        inflight_q, inflight_d;
    logic        inflight_epoch_q, inflight_epoch_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        epoch_q, epoch_d;

    logic        pop, push, req, fault;
    logic [1:0]  occupancy;
    logic [1:0]  wr_slot;
    logic [31:0] redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = (bus.redirect_pc[1:0] != 2'b00) ? StFault : StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    assign redirect_target = bus.redirect_pc;
    assign fault           = (state_q == StFault);
`else
    assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
    assign fault           = 1'b0;
`endif

    // Outputs are gated by rst_n so nothing leaks out while reset is held.
    assign bus.instr_valid = rst_n && (count_q != 2'd0);
    assign bus.instr       = fifo_q[0].instr;
    assign bus.instr_pc    = fifo_q[0].pc;
    assign bus.imem_addr   = pc_q;
    assign bus.imem_req    = req;
    assign bus.fetch_fault = rst_n && fault;

    assign pop       = bus.instr_valid && bus.instr_ready;
    // In-flight request reserves a FIFO slot, so the FIFO can never overflow.
    assign occupancy = count_q + {1'b0, inflight_q} - {1'b0, pop};
    assign req       = rst_n && !fault && !bus.redirect_valid && (occupancy < 2'd2);
    assign push      = inflight_q && bus.imem_rvalid && (inflight_epoch_q == epoch_q);
    assign wr_slot   = count_q - {1'b0, pop};

    always_comb begin
        pc_d             = pc_q;
        fifo_d[0]        = fifo_q[0];
        fifo_d[1]        = fifo_q[1];
        count_d          = count_q;
        epoch_d          = epoch_q;
        inflight_d       = req;
        inflight_epoch_d = inflight_epoch_q;
        inflight_pc_d    = inflight_pc_q;

        if (req) begin
            inflight_epoch_d = epoch_q;
            inflight_pc_d    = pc_q;
            pc_d             = pc_q + 32'd4;
        end

        if (bus.redirect_valid) begin
            // Flush wins over any push or pop this cycle; a pop still counts as consumed.
            count_d = 2'd0;
            epoch_d = ~epoch_q;
            pc_d    = redirect_target;
        end else begin
            if (pop) begin
                fifo_d[0] = fifo_q[1];
            end
            if (push) begin
                fifo_d[wr_slot[0]] = '{instr: bus.imem_rdata, pc: inflight_pc_q};
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC;
            fifo_q[0]        <= '0;
            fifo_q[1]        <= '0;
            count_q          <= 2'd0;
            epoch_q          <= 1'b0;
            inflight_q       <= 1'b0;
            inflight_epoch_q <= 1'b0;
            inflight_pc_q    <= '0;
        end else begin
            pc_q             <= pc_d;
            fifo_q[0]        <= fifo_d[0];
            fifo_q[1]        <= fifo_d[1];
            count_q          <= count_d;
            epoch_q          <= epoch_d;
            inflight_q       <= inflight_d;
            inflight_epoch_q <= inflight_epoch_d;
            inflight_pc_q    <= inflight_pc_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC fetched first after reset.
REQ-002 The block SHALL have ports:
  clk  input  1  single clock; all state updates on rising edge
  rst_n  input  1  synchronous active-low reset
  imem_req  output  1  instruction-memory read request
  imem_addr  output  32  byte address of the request
  imem_rvalid  input  1  read data valid, exactly one cycle after imem_req
  imem_rdata  input  32  instruction word
  redirect_valid  input  1  branch/jump redirect from execute
  redirect_pc  input  32  redirect target
  instr_valid  output  1  instr/instr_pc hold a fetched word for the decoder
  instr_ready  input  1  decoder accepts the word this cycle
  instr  output  32  instruction word to the decoder
  instr_pc  output  32  PC of instr
  fetch_fault  output  1  misaligned redirect seen (FETCH_ALIGN_CHECK_EN only; tied 0 otherwise)
REQ-003 Clocking and reset SHALL be one clock, clk; reset rst_n is synchronous and active-low.

Function
REQ-004 The block SHALL hold a 32-bit fetch PC, a 2-entry FIFO of {instr, pc}, an in-flight flag, and an epoch bit.
REQ-005 Output handshake: a word SHALL be transferred when instr_valid && instr_ready; instr_valid = FIFO not empty; instr/instr_pc = FIFO head, stable while valid && !ready.
REQ-006 Request issue: imem_req SHALL be 1 iff not in FAULT, no redirect_valid this cycle, and (count + inflight - pop) < 2, where pop = instr_valid && instr_ready.
REQ-007 On each issued request, imem_addr SHALL equal fetch PC; fetch PC SHALL advance by 4 (mod 2^32, wrap from FFFF_FFFC to 0000_0000 permitted).
REQ-008 Each request SHALL record the current epoch and PC; the matching imem_rvalid response SHALL be pushed to the FIFO tail only if its epoch equals the current epoch, else discarded.
REQ-009 Latency: response at cycle t+1 for request at t; instr_valid SHALL assert at t+2; with instr_ready held 1, one word per cycle is sustained.
REQ-010 Simultaneous push and pop SHALL keep count unchanged; count SHALL never exceed 2 and never underflow.
REQ-011 Redirect: in a redirect_valid cycle the FIFO SHALL be flushed, epoch toggled, fetch PC loaded with redirect_pc, no request issued; the first request at redirect_pc SHALL issue the following cycle.
REQ-012 A response returning in the redirect cycle or the cycle after SHALL be discarded by epoch mismatch.
REQ-013 Redirect and pop in the same cycle: the pop SHALL count as consumed by the decoder; the flush still empties the FIFO.
REQ-014 States: RUN (normal) and FAULT (only with FETCH_ALIGN_CHECK_EN); RUN->FAULT on misaligned redirect; FAULT->RUN on aligned redirect.

Reset
REQ-015 While rst_n = 0 at a clock edge: fetch PC = RESET_PC, FIFO empty, inflight = 0, epoch = 0, state = RUN.
REQ-016 During reset: imem_req = 0, instr_valid = 0, fetch_fault = 0; a response arriving in the first cycle after reset SHALL be dropped.
REQ-017 Reset mid-operation SHALL discard FIFO contents and any in-flight request; first request after release addresses RESET_PC.

Configuration
REQ-018 Macro FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0] != 0 SHALL flush, enter FAULT, hold fetch_fault = 1, issue no requests until an aligned redirect.
REQ-019 Macro undefined: redirect_pc[1:0] SHALL be forced to 00 on load, no FAULT state, fetch_fault tied 0.

Verification
REQ-020 Reset release, RESET_PC=0, ready=1, memory returns addr as data -> imem_addr 0,4,8,... every cycle; instr 0 at cycle 2, then one word per cycle.
REQ-021 ready=0 from start -> exactly 2 requests (0,4), FIFO full, imem_req=0; ready=1 -> words 0,4 pop in order, next request addr 8.
REQ-022 Redirect to 0x100 while FIFO holds 2 and 1 in flight -> in-flight response discarded; next instr_pc = 0x100, no stale word delivered.
REQ-023 Redirect and pop in same cycle -> no duplicate/stale output; next instr_pc = redirect target.
REQ-024 With macro, redirect to 0x102 -> fetch_fault=1, imem_req=0; redirect to 0x200 -> fetch_fault=0, fetch resumes at 0x200; without macro, 0x102 fetches 0x100.
REQ-025 rst_n low for 1 cycle mid-stream -> outputs clear next cycle; first request after release at RESET_PC.
